// File: rtl/even_odd_pkg.sv
// Shared definitions for the even_odd core front-end: dispatch FSM encoding and width defaults.
package even_odd_pkg;

   localparam int DW_DEF    = 32;
   localparam int TAG_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } state_t;

endpackage

// File: rtl/even_odd_res_fifo.sv
// Synchronous result FIFO of {data,tag,err} entries; head entry is presented straight from storage.
module even_odd_res_fifo #(
   parameter  int DW    = 32,
   parameter  int TAG_W = 4,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [DW-1:0]    push_data,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             push_err,
   input  logic             pop,
   output logic             rd_valid,
   output logic [DW-1:0]    rd_data,
   output logic [TAG_W-1:0] rd_tag,
   output logic             rd_err,
   output logic [CW-1:0]    count
);

   typedef struct packed {
      logic [DW-1:0]    data;
      logic [TAG_W-1:0] tag;
      logic             err;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign do_push  = push & (count != CW'(DEPTH));
   assign do_pop   = pop & (count != '0);
   assign rd_valid = (count != '0);
   assign rd_data  = mem[rd_ptr].data;
   assign rd_tag   = mem[rd_ptr].tag;
   assign rd_err   = mem[rd_ptr].err;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= '{data: push_data, tag: push_tag, err: push_err};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/even_odd_dispatch.sv
// Job front-end for the even_odd core: one-entry job buffer, start/done handshake, tagged result FIFO.
// Optional JOB_TIMEOUT_EN adds a WAIT watchdog that aborts the core and returns an error result.
module even_odd_dispatch
   import even_odd_pkg::*;
#(
   parameter  int DW             = DW_DEF,
   parameter  int TAG_W          = TAG_W_DEF,
   parameter  int RES_DEPTH      = 4,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int CW             = $clog2(RES_DEPTH) + 1
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [DW-1:0]    job_s,
   input  logic [DW-1:0]    job_e,
   output logic             core_start,
   output logic [DW-1:0]    core_s,
   output logic [DW-1:0]    core_e,
   input  logic             core_done,
   input  logic             core_idle,
   input  logic [DW-1:0]    core_return,
   output logic             core_rst,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DW-1:0]    res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err
);

   state_t           state_q, state_d;
   logic             buf_full;
   logic [DW-1:0]    buf_s, buf_e;
   logic [TAG_W-1:0] buf_tag, tag_cnt, run_tag;
   logic [CW-1:0]    fifo_count;
   logic             accept, launch_go, timeout;
   logic             push, push_err, pop;
   logic [DW-1:0]    push_data;

   assign job_ready = ~buf_full;
   assign accept    = job_valid & ~buf_full;
   assign pop       = res_valid & res_ready;
   // Launch only with a free FIFO slot, so the eventual push can never be dropped.
   assign launch_go = (state_q == IDLE) & buf_full & core_idle & (fifo_count < CW'(RES_DEPTH));

`ifdef JOB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge ap_clk) begin
      if (ap_rst || state_q != WAIT) to_cnt <= '0;
      else                           to_cnt <= to_cnt + 1'b1;
   end

   assign timeout  = (state_q == WAIT) & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign core_rst = timeout & ~core_done;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout        = 1'b0;
   assign core_rst       = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      core_start = 1'b0;
      push       = 1'b0;
      push_data  = core_return;
      push_err   = 1'b0;
      case (state_q)
         IDLE:   if (launch_go) state_d = LAUNCH;
         LAUNCH: begin
            core_start = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            // core_done takes priority over a coincident watchdog expiry
            if (core_done) begin
               push    = 1'b1;
               state_d = IDLE;
            end else if (timeout) begin
               push      = 1'b1;
               push_data = '0;
               push_err  = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q  <= IDLE;
         buf_full <= 1'b0;
         buf_s    <= '0;
         buf_e    <= '0;
         buf_tag  <= '0;
         tag_cnt  <= '0;
         run_tag  <= '0;
         core_s   <= '0;
         core_e   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            buf_full <= 1'b1;
            buf_s    <= job_s;
            buf_e    <= job_e;
            buf_tag  <= tag_cnt;
            tag_cnt  <= tag_cnt + 1'b1;
         end else if (state_q == LAUNCH) begin
            buf_full <= 1'b0;
         end
         // Operands land before LAUNCH so they are valid alongside core_start.
         if (launch_go) begin
            core_s  <= buf_s;
            core_e  <= buf_e;
            run_tag <= buf_tag;
         end
      end
   end

   even_odd_res_fifo #(
      .DW    (DW),
      .TAG_W (TAG_W),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .push      (push),
      .push_data (push_data),
      .push_tag  (run_tag),
      .push_err  (push_err),
      .pop       (pop),
      .rd_valid  (res_valid),
      .rd_data   (res_data),
      .rd_tag    (res_tag),
      .rd_err    (res_err),
      .count     (fifo_count)
   );

endmodule
